eiu: RTL
========

# eiu

Exception/interrupt unit for the RV32IM machine-mode-only core. It watches the commit stage and the three interrupt lines, decides when a trap or `mret` occurs, and kills the offending commit. It then drives the CSR file's trap inputs (`trap_en`, `mepc_from_eiu`, `mcause_from_eiu`, `mtval_from_eiu`, `mret_commit`) and redirects fetch through a flush handshake. It consumes the CSR file's `mtvec_r`, `mstatus_r`, `mepc_r` and `mie_r`.

## Interface
Parameters:
- none; widths are fixed at 32 bits (`ZCRV_XLEN`).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ext_irq / time_irq / soft_irq  in  1 each  level interrupt requests
- cmt_valid  in  1  an instruction is at commit this cycle
- cmt_pc  in  32  PC of the committing instruction
- cmt_inst  in  32  encoding of the committing instruction
- cmt_badaddr  in  32  faulting address (misaligned fetch target or load/store address)
- cmt_if_misalign, cmt_illegal, cmt_ebreak, cmt_ecall, cmt_ld_misalign, cmt_st_misalign, cmt_mret  in  1 each  commit-stage flags
- lsu_busy  in  1  load/store in flight; blocks interrupt entry
- mtvec_r, mstatus_r, mepc_r, mie_r  in  32 each  CSR views
- cmt_kill  out  1  combinational; suppresses the commit, including GPR/CSR writes and `inst_finish`
- trap_en  out  1  one-cycle trap-entry pulse to the CSR file
- mret_commit  out  1  one-cycle pulse to the CSR file
- mepc_from_eiu, mcause_from_eiu, mtval_from_eiu  out  32 each  registered trap record
- flush_req  out  1  pipeline flush request; held until acknowledged
- flush_pc  out  32  redirect target; valid while `flush_req`=1
- flush_ack  in  1  pipeline has taken the flush

## Operation
- Pending interrupt vector `irq_pend = {ext,time,soft} & {mie_r[11],mie_r[7],mie_r[3]}`.
- `irq_take = mstatus_r[3] & |irq_pend`.
- FSM states: IDLE, TRAP, MRET, REDIRECT.
- Conditions are evaluated only in IDLE with `cmt_valid`=1, in priority order:
  1. Exception, internal priority `if_misalign` > `illegal` > `ebreak` > `ecall` > `ld_misalign` > `st_misalign`.
     - mcause: 0, 2, 3, 11, 4, 6 respectively, with bit31=0.
     - mtval: `cmt_badaddr`, `cmt_inst`, `cmt_pc`, 0, `cmt_badaddr`, `cmt_badaddr` respectively.
     - mepc=`cmt_pc`; `cmt_kill`=1; next state TRAP.
  2. `cmt_mret`: the instruction commits (`cmt_kill`=0); target=`mepc_r`; next state MRET.
  3. `irq_take & ~lsu_busy`: internal priority ext (11) > soft (3) > time (7).
     - mcause = {1'b1, 27'b0, code}; mtval=0; mepc=`cmt_pc`; `cmt_kill`=1; next state TRAP.
- An interrupt is never taken while `cmt_valid`=0 or `lsu_busy`=1; it waits, level-sensitive.
- Trap target is computed at capture:
  - `mtvec_r[1:0]`==1 and interrupt: `{mtvec_r[31:2],2'b00} + 4*code`.
  - Otherwise (modes 0, 2, 3, or any exception): `{mtvec_r[31:2],2'b00}`.
- TRAP state: `trap_en`=1 for exactly one cycle, then REDIRECT.
- MRET state: `mret_commit`=1 for exactly one cycle, then REDIRECT.
- REDIRECT state: `flush_req`=1 with `flush_pc`=target; on `flush_ack`=1 go to IDLE next cycle.
- `cmt_kill`=1 in every non-IDLE state, whatever the value of `cmt_valid`.
- Simultaneous events:
  - Exception and interrupt in the same cycle: the exception wins. The interrupt stays pending; after entry MIE=0, so it is re-taken only once MIE is re-enabled.
  - An interrupt coinciding with a CSR instruction that clears MIE: the interrupt is taken and the CSR write is killed.

## Timing
- Reset values: all outputs 0, state IDLE. A reset mid-trap aborts immediately with no pulse emitted.
- Cycle N (capture): `cmt_kill` is combinational, in the same cycle as the flags. The trap record registers load at the N→N+1 edge.
- Cycle N+1: `trap_en` or `mret_commit` high. `mepc/mcause/mtval_from_eiu` are stable from N+1 until the next capture.
- Cycle N+2 onward: `flush_req` high until the `flush_ack` cycle inclusive. Minimum capture-to-IDLE is 3 cycles.
- Back-to-back traps are impossible: capture happens only in IDLE.

## Configuration
- `ZCRV_EIU_IRQ_SYNC_EN` defined: `ext_irq`, `time_irq` and `soft_irq` each pass through a 2-flop synchronizer (reset 0) before `irq_pend`, adding 2 cycles of interrupt latency.
- Undefined: the lines are used directly and must already be in the `clk` domain.

## Test plan
- Illegal instruction: `cmt_valid`=1, `cmt_illegal`=1, `cmt_pc`=0x100, `cmt_inst`=0xFFFFFFFF, `mtvec_r`=0x80.
  - Required: `cmt_kill`=1 at N; `trap_en` at N+1 with mepc=0x100, mcause=2, mtval=0xFFFFFFFF; `flush_pc`=0x80 at N+2.
- Vectored timer interrupt: `mtvec_r`=0x201, `mie_r[7]`=1, MIE=1, `time_irq`=1, `cmt_pc`=0x40.
  - Required: mcause=0x80000007, mepc=0x40, `flush_pc`=0x21C.
- Priority: ext+soft+time all pending and enabled → mcause=0x8000000B. ecall+ld_misalign together → mcause=11.
- Interrupt gating:
  - `lsu_busy`=1 for 5 cycles holds off entry; the trap is taken on the first `cmt_valid` cycle after `lsu_busy` falls.
  - MIE=0 → no trap.
- mret with `mepc_r`=0x300: `cmt_kill`=0; `mret_commit` pulses at N+1; `flush_pc`=0x300.
- Flush handshake and reset: holding `flush_ack`=0 for 4 cycles keeps `flush_req`=1 and `cmt_kill`=1. Asserting `rst_n`=0 mid-REDIRECT clears all outputs asynchronously.

Source files
------------

// File: rtl/eiu.sv
// rtl/eiu.sv - exception/interrupt unit: trap/mret capture, CSR trap record, fetch redirect
// Optional: define ZCRV_EIU_IRQ_SYNC_EN to pass the interrupt lines through 2-flop synchronizers.
module eiu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ext_irq,
   input  logic        time_irq,
   input  logic        soft_irq,
   input  logic        cmt_valid,
   input  logic [31:0] cmt_pc,
   input  logic [31:0] cmt_inst,
   input  logic [31:0] cmt_badaddr,
   input  logic        cmt_if_misalign,
   input  logic        cmt_illegal,
   input  logic        cmt_ebreak,
   input  logic        cmt_ecall,
   input  logic        cmt_ld_misalign,
   input  logic        cmt_st_misalign,
   input  logic        cmt_mret,
   input  logic        lsu_busy,
   input  logic [31:0] mtvec_r,
   input  logic [31:0] mstatus_r,
   input  logic [31:0] mepc_r,
   input  logic [31:0] mie_r,
   output logic        cmt_kill,
   output logic        trap_en,
   output logic        mret_commit,
   output logic [31:0] mepc_from_eiu,
   output logic [31:0] mcause_from_eiu,
   output logic [31:0] mtval_from_eiu,
   output logic        flush_req,
   output logic [31:0] flush_pc,
   input  logic        flush_ack
);

   typedef enum logic [1:0] {S_IDLE, S_TRAP, S_MRET, S_REDIRECT} state_t;

   state_t      state_q, state_d;
   logic        trap_en_q, trap_en_d;
   logic        mret_commit_q, mret_commit_d;
   logic        flush_req_q, flush_req_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [31:0] target_q, target_d;

   logic [2:0]  irq_lines;
   logic [2:0]  irq_pend;
   logic        irq_take;
   logic        exc_any;
   logic [3:0]  exc_code;
   logic [31:0] exc_tval;
   logic [3:0]  irq_code;
   logic [31:0] base;
   logic        csr_unused;

   assign csr_unused = ^{mie_r, mstatus_r};

`ifdef ZCRV_EIU_IRQ_SYNC_EN
   logic [2:0] irq_s1_q, irq_s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_s1_q <= '0;
         irq_s2_q <= '0;
      end else begin
         irq_s1_q <= {ext_irq, time_irq, soft_irq};
         irq_s2_q <= irq_s1_q;
      end
   end
   assign irq_lines = irq_s2_q;
`else
   assign irq_lines = {ext_irq, time_irq, soft_irq};
`endif

   always_comb begin
      irq_pend = irq_lines & {mie_r[11], mie_r[7], mie_r[3]};
      irq_take = mstatus_r[3] & (|irq_pend);
      exc_any  = cmt_if_misalign | cmt_illegal | cmt_ebreak | cmt_ecall |
                 cmt_ld_misalign | cmt_st_misalign;
      base     = {mtvec_r[31:2], 2'b00};

      exc_code = 4'd6;
      exc_tval = cmt_badaddr;
      if (cmt_if_misalign) begin
         exc_code = 4'd0;
         exc_tval = cmt_badaddr;
      end else if (cmt_illegal) begin
         exc_code = 4'd2;
         exc_tval = cmt_inst;
      end else if (cmt_ebreak) begin
         exc_code = 4'd3;
         exc_tval = cmt_pc;
      end else if (cmt_ecall) begin
         exc_code = 4'd11;
         exc_tval = '0;
      end else if (cmt_ld_misalign) begin
         exc_code = 4'd4;
         exc_tval = cmt_badaddr;
      end

      // ext beats soft beats time, unlike the bit order of irq_pend
      if (irq_pend[2])      irq_code = 4'd11;
      else if (irq_pend[0]) irq_code = 4'd3;
      else                  irq_code = 4'd7;

      state_d       = state_q;
      trap_en_d     = 1'b0;
      mret_commit_d = 1'b0;
      flush_req_d   = 1'b0;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      target_d      = target_q;
      cmt_kill      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmt_valid) begin
               if (exc_any) begin
                  cmt_kill  = 1'b1;
                  trap_en_d = 1'b1;
                  state_d   = S_TRAP;
                  mepc_d    = cmt_pc;
                  mcause_d  = {28'b0, exc_code};
                  mtval_d   = exc_tval;
                  target_d  = base;
               end else if (cmt_mret) begin
                  mret_commit_d = 1'b1;
                  state_d       = S_MRET;
                  target_d      = mepc_r;
               end else if (irq_take && !lsu_busy) begin
                  cmt_kill  = 1'b1;
                  trap_en_d = 1'b1;
                  state_d   = S_TRAP;
                  mepc_d    = cmt_pc;
                  mcause_d  = {1'b1, 27'b0, irq_code};
                  mtval_d   = '0;
                  target_d  = (mtvec_r[1:0] == 2'b01) ? base + {26'b0, irq_code, 2'b00} : base;
               end
            end
         end
         S_TRAP, S_MRET: begin
            cmt_kill    = 1'b1;
            flush_req_d = 1'b1;
            state_d     = S_REDIRECT;
         end
         default: begin
            cmt_kill = 1'b1;
            if (flush_ack) state_d = S_IDLE;
            else           flush_req_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         trap_en_q     <= 1'b0;
         mret_commit_q <= 1'b0;
         flush_req_q   <= 1'b0;
         mepc_q        <= '0;
         mcause_q      <= '0;
         mtval_q       <= '0;
         target_q      <= '0;
      end else begin
         state_q       <= state_d;
         trap_en_q     <= trap_en_d;
         mret_commit_q <= mret_commit_d;
         flush_req_q   <= flush_req_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         target_q      <= target_d;
      end
   end

   assign trap_en         = trap_en_q;
   assign mret_commit     = mret_commit_q;
   assign flush_req       = flush_req_q;
   assign flush_pc        = target_q;
   assign mepc_from_eiu   = mepc_q;
   assign mcause_from_eiu = mcause_q;
   assign mtval_from_eiu  = mtval_q;

endmodule
